// File: rtl/cdbus_sim_pkg.sv
// Shared definitions for the cdbus simulation bus model: line levels, idle FSM states
// and a width-generic saturating increment.
package cdbus_sim_pkg;

  localparam logic REC = 1'b1;
  localparam logic DOM = 1'b0;

  typedef enum logic {
    BUSY  = 1'b0,
    QUIET = 1'b1
  } idle_state_t;

  // Saturates at 2^width-1; callers truncate the result back to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/cdbus_delay_line.sv
// Line propagation delay: a DELAY-stage shift register that resets to RESET_VAL,
// or a plain wire when DELAY is 0.
module cdbus_delay_line #(
  parameter int   DELAY     = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  generate
    if (DELAY == 0) begin : g_bypass
      logic unused_clk_reset;
      assign unused_clk_reset = clk ^ reset;
      assign dout = din;
    end else begin : g_pipe
      logic [DELAY-1:0] stages;

      // The cast drops the oldest bit, which also covers the single-stage case.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stages <= {DELAY{RESET_VAL}};
        end else begin
          stages <= DELAY'({stages, din});
        end
      end

      assign dout = stages[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/cdbus_bus_model.sv
// Shared cdbus line model: wired-AND resolution of all nodes, propagation delay,
// collision/overlap counting and an idle detector.
module cdbus_bus_model
  import cdbus_sim_pkg::*;
#(
  parameter int NODES       = 4,
  parameter int DELAY       = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NODES-1:0] tx,
  input  logic [NODES-1:0] tx_en,
  output logic [NODES-1:0] rx,
  input  logic             force_low,
  input  logic             clr_cnt,
  output logic             bus_line,
  output logic             bus_idle,
  output logic             collision,
  output logic [CNT_W-1:0] collision_cnt,
  output logic [CNT_W-1:0] overlap_cnt
);

  localparam int QW = $clog2(IDLE_CYCLES + 1);
  localparam logic [QW-1:0] IDLE_MAX = QW'(IDLE_CYCLES);

  logic        raw;
  logic        conflict;
  logic        overlap;
  logic        quiet;
  idle_state_t state;
  logic [QW-1:0] quiet_cnt;

  // Any enabled dominant driver or the fault input pulls the line low.
  assign raw = (force_low || (|(tx_en & ~tx))) ? DOM : REC;

  cdbus_delay_line #(
    .DELAY    (DELAY),
    .RESET_VAL(REC)
  ) u_delay_line (
    .clk  (clk),
    .reset(reset),
    .din  (raw),
    .dout (bus_line)
  );

  assign rx = (tx_en & tx) | (~tx_en & {NODES{bus_line}});

  // Clearing the lowest set bit leaves something only when two or more drivers are enabled.
  assign conflict = (|(tx_en & tx)) && (|(tx_en & ~tx));
  assign overlap  = |(tx_en & (tx_en - NODES'(1)));
  assign quiet    = (bus_line == REC) && (tx_en == '0) && !force_low;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collision     <= 1'b0;
      collision_cnt <= '0;
      overlap_cnt   <= '0;
    end else begin
      collision <= conflict;
      if (clr_cnt) begin
        collision_cnt <= '0;
        overlap_cnt   <= '0;
      end else begin
        if (conflict) collision_cnt <= CNT_W'(sat_inc(32'(collision_cnt), CNT_W));
        if (overlap)  overlap_cnt   <= CNT_W'(sat_inc(32'(overlap_cnt), CNT_W));
      end
    end
  end

  // bus_idle is registered from the count value being loaded, so it rises on the
  // same edge that brings the quiet run up to IDLE_CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BUSY;
      quiet_cnt <= '0;
      bus_idle  <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          if (quiet) begin
            state     <= QUIET;
            quiet_cnt <= QW'(1);
            bus_idle  <= (IDLE_MAX == QW'(1));
          end
        end
        QUIET: begin
          if (quiet) begin
            if (quiet_cnt != IDLE_MAX) quiet_cnt <= quiet_cnt + QW'(1);
            bus_idle <= (quiet_cnt == IDLE_MAX) || (quiet_cnt == IDLE_MAX - QW'(1));
          end else begin
            state     <= BUSY;
            quiet_cnt <= '0;
            bus_idle  <= 1'b0;
          end
        end
        default: begin
          state     <= BUSY;
          quiet_cnt <= '0;
          bus_idle  <= 1'b0;
        end
      endcase
    end
  end

endmodule
